baccarat_statemachine: RTL and testbench

Control FSM for the baccarat card game: sequences dealing of the first four cards, applies the player and banker third-card rules, then lights the winner. It sits between the card-dealing/scoring datapath and the win-indicator lights. It receives hand scores and the player's third card from the datapath and returns one-hot card-load strobes. All outputs are Moore (decoded from state only).

---
 rtl/baccarat_statemachine.sv | 107 ++++++++++
 tb/tb_baccarat_statemachine.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/baccarat_statemachine.sv
// baccarat_statemachine
// Control FSM for a baccarat table. It deals the first four cards, applies
// the player and banker third-card rules, and then lights the winner.
// Every output is decoded from registered state only.
//
// Ports
//   slow_clock       in   game clock; all state changes happen on its rising edge
//   resetb           in   synchronous, active-low reset
//   dscore[3:0]      in   banker hand score
//   pscore[3:0]      in   player hand score
//   pcard3[3:0]      in   value of the player's third card
//   load_pcard1..3   out  player card-load strobes (one-hot while dealing)
//   load_dcard1..3   out  dealer card-load strobes (one-hot while dealing)
//   player_win_light out  player wins (both lights are on for a tie)
//   dealer_win_light out  dealer wins (both lights are on for a tie)
module baccarat_statemachine (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] dscore,
  input  logic [3:0] pscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  typedef enum logic [2:0] {
    P1, D1, P2, D2, P3, D3, CALC, RESULT
  } state_t;

  state_t state_q, state_d;
  logic   pwin_q, pwin_d;
  logic   dwin_q, dwin_d;

  // Banker third-card rule, applied once the player has drawn a third card.
  // Score and card values above 9 are compared as-is.
  function automatic logic banker_draws(input logic [3:0] ds, input logic [3:0] pc);
    logic draw;
    draw = 1'b0;
    if (ds <= 4'd2)       draw = 1'b1;
    else if (ds == 4'd3)  draw = (pc != 4'd8);
    else if (ds == 4'd4)  draw = (pc >= 4'd2) && (pc <= 4'd7);
    else if (ds == 4'd5)  draw = (pc >= 4'd4) && (pc <= 4'd7);
    else if (ds == 4'd6)  draw = (pc >= 4'd6) && (pc <= 4'd7);
    return draw;
  endfunction

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q <= P1;
      pwin_q  <= 1'b0;
      dwin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pwin_q  <= pwin_d;
      dwin_q  <= dwin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pwin_d  = 1'b0;
    dwin_d  = 1'b0;
    case (state_q)
      P1:   state_d = D1;
      D1:   state_d = P2;
      P2:   state_d = D2;
      D2: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) state_d = CALC;
        else if (pscore <= 4'd5)                  state_d = P3;
        else if (dscore <= 4'd5)                  state_d = D3;
        else                                      state_d = CALC;
      end
      P3:   state_d = banker_draws(dscore, pcard3) ? D3 : CALC;
      D3:   state_d = CALC;
      CALC: begin
        // The lights are captured from the final scores as RESULT is entered.
        state_d = RESULT;
        pwin_d  = (pscore >= dscore);
        dwin_d  = (dscore >= pscore);
      end
      RESULT: begin
        state_d = RESULT;
        pwin_d  = pwin_q;
        dwin_d  = dwin_q;
      end
      default: state_d = P1;
    endcase
  end

  // The win lights are nonzero only while in RESULT, so they are driven
  // straight from their registers.
  assign load_pcard1      = (state_q == P1);
  assign load_dcard1      = (state_q == D1);
  assign load_pcard2      = (state_q == P2);
  assign load_dcard2      = (state_q == D2);
  assign load_pcard3      = (state_q == P3);
  assign load_dcard3      = (state_q == D3);
  assign player_win_light = pwin_q;
  assign dealer_win_light = dwin_q;

endmodule

// File: tb/tb_baccarat_statemachine.sv
module tb_baccarat_statemachine;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] dscore, pscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;

  int checks   = 0;
  int failures = 0;

  // Output vector order: {pc1, pc2, pc3, dc1, dc2, dc3, pwin, dwin}
  localparam logic [7:0] O_P1   = 8'b1000_0000;
  localparam logic [7:0] O_P2   = 8'b0100_0000;
  localparam logic [7:0] O_P3   = 8'b0010_0000;
  localparam logic [7:0] O_D1   = 8'b0001_0000;
  localparam logic [7:0] O_D2   = 8'b0000_1000;
  localparam logic [7:0] O_D3   = 8'b0000_0100;
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_PWIN = 8'b0000_0010;
  localparam logic [7:0] O_DWIN = 8'b0000_0001;
  localparam logic [7:0] O_TIE  = 8'b0000_0011;

  logic [7:0] exp_q[$];

  baccarat_statemachine dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .dscore           (dscore),
    .pscore           (pscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  function automatic logic [7:0] outs();
    return {load_pcard1, load_pcard2, load_pcard3, load_dcard1,
            load_dcard2, load_dcard3, player_win_light, dealer_win_light};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Queue the expected outputs, clock once, then pop and compare.
  task automatic step(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    @(posedge slow_clock);
    #1;
    e = exp_q.pop_front();
    chk(tag, outs(), e);
  endtask

  // Reset, then deal the first four cards, finishing in D2.
  task automatic start_game(input logic [3:0] d, input logic [3:0] p);
    dscore = d;
    pscore = p;
    pcard3 = 4'd0;
    resetb = 1'b0;
    step("reset_p1", O_P1);
    resetb = 1'b1;
    step("edge1_d1", O_D1);
    step("edge2_p2", O_P2);
    step("edge3_d2", O_D2);
  endtask

  task automatic p3_case(input string tag, input logic [3:0] d,
                         input logic [3:0] pc, input logic [7:0] exp);
    start_game(4'd3, 4'd4);
    step("reach_p3", O_P3);
    dscore = d;
    pcard3 = pc;
    step(tag, exp);
  endtask

  initial begin
    resetb = 1'b0;
    dscore = 4'd0;
    pscore = 4'd0;
    pcard3 = 4'd0;
    #1;

    // Naturals
    start_game(4'd9, 4'd6);
    step("nat_d_calc", O_NONE);
    step("nat_dealer", O_DWIN);
    start_game(4'd6, 4'd9);
    step("nat_p_calc", O_NONE);
    step("nat_player", O_PWIN);
    start_game(4'd9, 4'd9);
    step("nat_t_calc", O_NONE);
    step("nat_tie", O_TIE);
    step("nat_tie_hold", O_TIE);
    start_game(4'd8, 4'd2);
    step("nat_d8_calc", O_NONE);

    // D2 exit decisions
    start_game(4'd6, 4'd4);
    step("player_draws", O_P3);
    start_game(4'd6, 4'd5);
    step("p5_draws", O_P3);
    start_game(4'd4, 4'd7);
    step("banker_draws", O_D3);
    start_game(4'd5, 4'd6);
    step("p6_d5_d3", O_D3);
    start_game(4'd6, 4'd6);
    step("p6_d6_calc", O_NONE);

    // Banker rule at P3
    p3_case("p3_d7", 4'd7, 4'd5, O_NONE);
    p3_case("p3_d6_c6", 4'd6, 4'd6, O_D3);
    p3_case("p3_d5_c5", 4'd5, 4'd5, O_D3);
    p3_case("p3_d4_c5", 4'd4, 4'd5, O_D3);
    p3_case("p3_d3_c7", 4'd3, 4'd7, O_D3);
    p3_case("p3_d0_c5", 4'd0, 4'd5, O_D3);
    p3_case("p3_d3_c8", 4'd3, 4'd8, O_NONE);
    p3_case("p3_d6_c5", 4'd6, 4'd5, O_NONE);
    p3_case("p3_d4_c1", 4'd4, 4'd1, O_NONE);
    p3_case("p3_d5_c3", 4'd5, 4'd3, O_NONE);
    p3_case("p3_d4_c7", 4'd4, 4'd7, O_D3);

    // Longest path P3 -> D3 -> CALC -> RESULT, dealer ahead
    p3_case("long_d3", 4'd2, 4'd4, O_D3);
    pscore = 4'd1;
    step("long_calc", O_NONE);
    step("long_dealer", O_DWIN);

    // Full path through D3 with player ahead
    start_game(4'd4, 4'd7);
    step("full_d3", O_D3);
    step("full_calc", O_NONE);
    step("full_player", O_PWIN);
    for (int i = 0; i < 3; i++) begin
      dscore = 4'(i + 7);
      step("full_hold", O_PWIN);
    end

    // Reset from RESULT
    resetb = 1'b0;
    step("rst_from_result", O_P1);

    // Reset from D3
    start_game(4'd4, 4'd7);
    step("pre_rst_d3", O_D3);
    resetb = 1'b0;
    step("rst_from_d3", O_P1);
    resetb = 1'b1;
    step("after_rst_d1", O_D1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
